// File: rtl/fft_pwr_reader.sv
// Averages 2^NAVG_LOG2 power frames per bin, snapshots the averaged spectrum and
// streams it one bin per valid/ready beat while tracking the peak non-DC bin.
module fft_pwr_reader #(
    parameter int NAVG_LOG2 = 2,
    parameter int PW        = 35,
    parameter int NBIN      = 17
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               en,
    input  logic               frame_valid,
    input  logic [NBIN*PW-1:0] pwr_bus,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PW-1:0]      out_data,
    output logic [4:0]         out_bin,
    output logic               out_last,
    output logic [4:0]         peak_bin,
    output logic [PW-1:0]      peak_pwr,
    output logic               peak_valid,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam int AW = PW + NAVG_LOG2;
    localparam logic [NAVG_LOG2-1:0] CNT_LAST = '1;
    localparam logic [4:0] BIN_LAST = 5'(NBIN - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    // Arithmetic shift floors toward -inf; the quotient always fits in PW bits.
    function automatic logic signed [PW-1:0] avg_trunc(input logic signed [AW-1:0] sum);
        return PW'(sum >>> NAVG_LOG2);
    endfunction

    state_t                 state_q, state_d;
    logic [NAVG_LOG2-1:0]   cnt_q, cnt_d;
    logic signed [AW-1:0]   acc_q [NBIN];
    logic signed [AW-1:0]   acc_d [NBIN];
    logic signed [PW-1:0]   snap_q [NBIN];
    logic signed [PW-1:0]   snap_d [NBIN];
    logic signed [PW-1:0]   pwr_s [NBIN];
    logic signed [AW-1:0]   sum_s [NBIN];
    logic [4:0]             idx_q, idx_d;
    logic signed [PW-1:0]   run_max_q, run_max_d;
    logic [4:0]             run_bin_q, run_bin_d;
    logic signed [PW-1:0]   peak_pwr_q, peak_pwr_d;
    logic [4:0]             peak_bin_q, peak_bin_d;
    logic                   peak_valid_q, peak_valid_d;
    logic                   ovf_q, ovf_d;
    logic                   hs, last_hs, complete, buf_free;
    logic signed [PW-1:0]   cur_data;

    always_comb begin
        for (int k = 0; k < NBIN; k++) begin
            pwr_s[k] = pwr_bus[PW*k +: PW];
            if (cnt_q == '0) begin
                sum_s[k] = {{NAVG_LOG2{pwr_s[k][PW-1]}}, pwr_s[k]};
            end else begin
                sum_s[k] = acc_q[k] + {{NAVG_LOG2{pwr_s[k][PW-1]}}, pwr_s[k]};
            end
        end
    end

    always_comb begin
        cur_data = snap_q[idx_q];
        hs       = (state_q == S_STREAM) && out_ready;
        last_hs  = hs && (idx_q == BIN_LAST);
        complete = en && frame_valid && (cnt_q == CNT_LAST);
        buf_free = (state_q == S_IDLE) || last_hs;
    end

    always_comb begin
        out_valid  = (state_q == S_STREAM);
        out_data   = out_valid ? cur_data : '0;
        out_bin    = out_valid ? idx_q : '0;
        out_last   = out_valid && (idx_q == BIN_LAST);
        peak_bin   = peak_bin_q;
        peak_pwr   = peak_pwr_q;
        peak_valid = peak_valid_q;
        ovf        = ovf_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NBIN; k++) begin
            acc_d[k] = acc_q[k];
        end
        if (!en) begin
            cnt_d = '0;
            for (int k = 0; k < NBIN; k++) begin
                acc_d[k] = '0;
            end
        end else if (frame_valid) begin
            cnt_d = complete ? '0 : cnt_q + 1'b1;
            for (int k = 0; k < NBIN; k++) begin
                acc_d[k] = sum_s[k];
            end
        end
    end

    // Stream FSM; a completion landing on the last handshake reloads without a gap.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < NBIN; k++) begin
            snap_d[k] = snap_q[k];
        end
        if (hs) begin
            if (idx_q == BIN_LAST) begin
                state_d = S_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (complete) begin
            if (buf_free) begin
                state_d = S_STREAM;
                idx_d   = '0;
                for (int k = 0; k < NBIN; k++) begin
                    snap_d[k] = avg_trunc(sum_s[k]);
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Running max over accepted beats 1..NBIN-1; strict compare keeps the lowest index on ties.
    always_comb begin
        run_max_d    = run_max_q;
        run_bin_d    = run_bin_q;
        peak_pwr_d   = peak_pwr_q;
        peak_bin_d   = peak_bin_q;
        peak_valid_d = 1'b0;
        if (hs) begin
            if (idx_q == 5'd1) begin
                run_max_d = cur_data;
                run_bin_d = 5'd1;
            end else if ((idx_q > 5'd1) && (cur_data > run_max_q)) begin
                run_max_d = cur_data;
                run_bin_d = idx_q;
            end
            if (idx_q == BIN_LAST) begin
                peak_valid_d = 1'b1;
                peak_bin_d   = run_bin_d;
                peak_pwr_d   = run_max_d;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            run_max_q    <= '0;
            run_bin_q    <= '0;
            peak_pwr_q   <= '0;
            peak_bin_q   <= '0;
            peak_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            for (int k = 0; k < NBIN; k++) begin
                acc_q[k]  <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            run_max_q    <= run_max_d;
            run_bin_q    <= run_bin_d;
            peak_pwr_q   <= peak_pwr_d;
            peak_bin_q   <= peak_bin_d;
            peak_valid_q <= peak_valid_d;
            ovf_q        <= ovf_d;
            for (int k = 0; k < NBIN; k++) begin
                acc_q[k]  <= acc_d[k];
                snap_q[k] <= snap_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fft_pwr_reader.sv
// Directed and randomized bench for fft_pwr_reader, checked against a
// spectrum-level reference model (frame sums, floor averages, beat queue).
module tb_fft_pwr_reader;

    localparam int NAVG_LOG2 = 2;
    localparam int NA        = 4;
    localparam int PW        = 35;
    localparam int NBIN      = 17;

    logic                   clk, arst, en, frame_valid, out_ready, ovf_clr;
    logic [NBIN*PW-1:0]     pwr_bus;
    logic                   out_valid, out_last, peak_valid, ovf;
    logic signed [PW-1:0]   out_data, peak_pwr;
    logic [4:0]             out_bin, peak_bin;

    fft_pwr_reader #(.NAVG_LOG2(NAVG_LOG2), .PW(PW), .NBIN(NBIN)) dut (
        .clk(clk), .arst(arst), .en(en), .frame_valid(frame_valid), .pwr_bus(pwr_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bin(out_bin),
        .out_last(out_last), .peak_bin(peak_bin), .peak_pwr(peak_pwr), .peak_valid(peak_valid),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { longint data; int bin; bit last; } beat_t;
    typedef struct { int bin; longint pwr; } peak_t;

    beat_t   exp_q[$];
    peak_t   pk_q[$];
    longint  msum [NBIN];
    longint  fr [NBIN];
    int      mcnt;
    bit      ovf_exp, pv_exp;
    int      pb_exp;
    longint  pp_exp;
    bit      rnd_ready, stalled;
    logic [63:0] s_data, s_bin, s_last;
    int      beat_cnt;
    int      checks, errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic longint floor_avg(input longint s);
        longint q;
        q = s / NA;
        if ((s % NA != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        pk_q.delete();
        for (int k = 0; k < NBIN; k++) msum[k] = 0;
        mcnt = 0; ovf_exp = 0; pv_exp = 0; pb_exp = 0; pp_exp = 0; stalled = 0;
    endtask

    // One clock: sample pre-edge, advance the model across the edge, check post-edge.
    task automatic tick();
        bit hs, drop, free;
        logic [63:0] d, b, l;
        int npend, best;
        longint avg [NBIN];
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        if (stalled && out_valid) begin
            chk("stall_data", out_data, s_data);
            chk("stall_bin", out_bin, s_bin);
            chk("stall_last", out_last, s_last);
        end
        hs = out_valid && out_ready;
        d = out_data; b = out_bin; l = out_last;
        stalled = out_valid && !out_ready;
        s_data = out_data; s_bin = out_bin; s_last = out_last;
        @(posedge clk);
        #1;
        npend = exp_q.size();
        pv_exp = 0;
        drop = 0;
        if (hs) begin
            beat_cnt++;
            if (npend == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                chk("beat_data", d, exp_q[0].data);
                chk("beat_bin", b, exp_q[0].bin);
                chk("beat_last", l, exp_q[0].last);
                if (exp_q[0].last && pk_q.size() > 0) begin
                    pv_exp = 1;
                    pb_exp = pk_q[0].bin;
                    pp_exp = pk_q[0].pwr;
                    void'(pk_q.pop_front());
                end
                void'(exp_q.pop_front());
            end
        end
        if (!en) begin
            mcnt = 0;
            for (int k = 0; k < NBIN; k++) msum[k] = 0;
        end else if (frame_valid) begin
            for (int k = 0; k < NBIN; k++) msum[k] += fr[k];
            mcnt++;
            if (mcnt == NA) begin
                free = (npend == 0) || (npend == 1 && hs);
                if (free) begin
                    for (int k = 0; k < NBIN; k++) begin
                        avg[k] = floor_avg(msum[k]);
                        exp_q.push_back('{data: avg[k], bin: k, last: (k == NBIN - 1)});
                    end
                    best = 1;
                    for (int k = 2; k < NBIN; k++) if (avg[k] > avg[best]) best = k;
                    pk_q.push_back('{bin: best, pwr: avg[best]});
                end else begin
                    drop = 1;
                end
                mcnt = 0;
                for (int k = 0; k < NBIN; k++) msum[k] = 0;
            end
        end
        if (drop) ovf_exp = 1;
        else if (ovf_clr) ovf_exp = 0;
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("cur_bin", out_bin, exp_q[0].bin);
            chk("cur_data", out_data, exp_q[0].data);
            chk("cur_last", out_last, exp_q[0].last);
        end
        chk("ovf", ovf, ovf_exp);
        chk("peak_valid", peak_valid, pv_exp);
        chk("peak_bin", peak_bin, pb_exp);
        chk("peak_pwr", peak_pwr, pp_exp);
    endtask

    task automatic load_bus();
        for (int k = 0; k < NBIN; k++) pwr_bus[PW*k +: PW] = fr[k][PW-1:0];
    endtask

    task automatic send_frame();
        load_bus();
        frame_valid = 1;
        tick();
        frame_valid = 0;
        tick();
    endtask

    task automatic rand_frame();
        logic [63:0] r;
        logic signed [PW-1:0] t;
        for (int k = 0; k < NBIN; k++) begin
            r = {$urandom(), $urandom()};
            t = r[PW-1:0];
            fr[k] = t;
        end
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() > 0; i++) tick();
        chk("drain_timeout", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        #2 arst = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_bin", peak_bin, 0);
        chk("rst_peak_pwr", peak_pwr, 0);
        model_clear();
        #10 arst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b3 [4] = '{1, 2, 3, 5};
        checks = 0; errors = 0; beat_cnt = 0; rnd_ready = 0;
        arst = 0; en = 0; frame_valid = 0; out_ready = 0; ovf_clr = 0; pwr_bus = '0;
        model_clear();
        #1 arst = 1;
        #2;
        chk("init_out_valid", out_valid, 0);
        chk("init_out_data", out_data, 0);
        chk("init_out_bin", out_bin, 0);
        chk("init_ovf", ovf, 0);
        chk("init_peak_valid", peak_valid, 0);
        chk("init_peak_bin", peak_bin, 0);
        #9 arst = 0;
        @(posedge clk);
        #1;

        // Ramp spectrum, always ready
        en = 1; out_ready = 1; beat_cnt = 0;
        for (int k = 0; k < NBIN; k++) fr[k] = 100 * k;
        repeat (4) send_frame();
        drain(40);
        chk("t1_beats", beat_cnt, 17);
        chk("t1_peak_bin", peak_bin, 16);
        chk("t1_peak_pwr", peak_pwr, 1600);

        // DC excluded from the peak
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NBIN; k++) fr[k] = 0;
            fr[0] = 1000;
            fr[3] = b3[f];
            send_frame();
        end
        drain(40);
        chk("t2_peak_bin", peak_bin, 3);
        chk("t2_peak_pwr", peak_pwr, 2);

        // Random data (including negatives) with random back-pressure
        rnd_ready = 1;
        for (int f = 0; f < 16; f++) begin
            rand_frame();
            send_frame();
            repeat ($urandom_range(0, 20)) tick();
        end
        drain(400);
        rnd_ready = 0; out_ready = 1;

        // Tie between bins 4 and 9 after an en drop discards partial frames
        for (int k = 0; k < NBIN; k++) fr[k] = 90000 + k;
        send_frame();
        send_frame();
        en = 0;
        tick();
        en = 1;
        for (int k = 0; k < NBIN; k++) fr[k] = 10 * k;
        fr[4] = 500; fr[9] = 500;
        beat_cnt = 0;
        repeat (4) send_frame();
        drain(40);
        chk("tie_beats", beat_cnt, 17);
        chk("tie_peak_bin", peak_bin, 4);
        chk("tie_peak_pwr", peak_pwr, 500);

        // Overflow while stalled; clear; set wins over a simultaneous clear
        out_ready = 0;
        for (int f = 0; f < 8; f++) begin
            rand_frame();
            send_frame();
        end
        chk("ovf_set", ovf, 1);
        chk("ovf_hold_bin", out_bin, 0);
        chk("ovf_hold_valid", out_valid, 1);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("ovf_cleared", ovf, 0);
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame();
        end
        rand_frame();
        load_bus();
        frame_valid = 1; ovf_clr = 1;
        tick();
        frame_valid = 0; ovf_clr = 0;
        tick();
        chk("ovf_set_wins", ovf, 1);
        beat_cnt = 0;
        out_ready = 1;
        drain(60);
        chk("ovf_one_spectrum", beat_cnt, 17);

        // Asynchronous reset in mid-stream
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            send_frame();
        end
        for (int i = 0; i < 40 && !(out_valid && out_bin == 5'd7); i++) tick();
        chk("reach_bin7", out_bin, 7);
        do_reset();
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame();
        end
        chk("no_out_after_rst", out_valid, 0);
        beat_cnt = 0;
        rand_frame();
        send_frame();
        drain(40);
        chk("rst_new_spectrum", beat_cnt, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_pwr_reader.md
Name: fft_pwr_reader

Overview:
Consumer of the registered 17-bin power spectrum produced by the FFT power stage. It averages 2^NAVG_LOG2 consecutive power frames per bin and snapshots the averaged spectrum. It then streams the snapshot out one bin per beat over a valid/ready interface and reports the peak non-DC bin. It sits between the power stage and the capture/readout logic of the FFT testbench.

Parameters:
NAVG_LOG2, 2, log2 of frames averaged per output spectrum (1..6)
PW, 35, width of one signed power bin
NBIN, 17, bins per frame (fixed at 17 for 32-point FFT)

Ports:
clk  in  1  clock
arst  in  1  asynchronous reset, active-high
en  in  1  averaging enable; low clears the accumulators and the frame count
frame_valid  in  1  one-cycle pulse: pwr_bus holds a new frame
pwr_bus  in  NBIN*PW  packed bins; bin k at [PW*k+PW-1 : PW*k], signed
out_valid  out  1  streamed bin valid
out_ready  in  1  downstream accept
out_data  out  PW  averaged power of bin out_bin, signed
out_bin  out  5  bin index 0..16
out_last  out  1  high with bin 16
peak_bin  out  5  index of max averaged bin among 1..16
peak_pwr  out  PW  value at peak_bin
peak_valid  out  1  one-cycle pulse when peak_bin/peak_pwr update
ovf  out  1  sticky: an averaged spectrum was dropped
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (arst high, async): state IDLE, frame count 0, accumulators 0, snapshot 0, stream index 0. All outputs 0, including ovf.
- Reset asserted mid-stream aborts the stream; out_last is not emitted. After release a full new set of 2^NAVG_LOG2 frames is required.
- Accumulation, with en=1 and frame_valid=1:
  - If the count is 0, acc[k] <= pwr[k]; otherwise acc[k] <= acc[k] + pwr[k]. Then count++.
  - Accumulator width is PW+NAVG_LOG2, signed; no overflow is possible.
- frame_valid with en=0 is ignored. en=0 clears count and accumulators the next edge and does not disturb a stream in progress.
- Completion, on the frame where count == 2^NAVG_LOG2-1:
  - avg[k] = (acc[k]+pwr[k]) >>> NAVG_LOG2, an arithmetic shift that truncates toward -inf, kept to PW bits.
  - count returns to 0.
  - The snapshot buffer is free if state=IDLE, or if state=STREAM and the out_last beat handshakes in the same cycle.
  - Free buffer: load the snapshot, index <= 0, state <= STREAM.
  - Busy buffer: discard the average, set ovf; the current stream continues unaffected.
- Latency: out_valid asserts the cycle after the completing frame_valid is sampled.
- FSM:
  - IDLE: out_valid=0. Go to STREAM on snapshot load.
  - STREAM: out_valid=1, out_data=snap[index], out_bin=index, out_last=(index==16).
  - On out_valid&&out_ready: index++. On the last beat, go to IDLE, or reload and stay in STREAM if a completion coincides.
  - out_data, out_bin and out_last are held stable while out_valid && !out_ready.
- Peak search runs over accepted beats of bins 1..16; bin 0 (DC) is excluded.
  - Strict greater-than comparison, so on ties the lowest index wins. The running max starts from bin 1's value.
  - On the last beat, the edge writes peak_bin/peak_pwr and pulses peak_valid high for the one following cycle. The values hold until the next stream completes.
- ovf_clr clears ovf. If ovf_clr and a new drop occur in the same cycle, set wins.
- Negative inputs, which do not occur in normal operation, are averaged arithmetically without clamping.

Test Plan:
- NAVG_LOG2=2, 4 frames with bin k = 100*k, out_ready=1 -> 17 beats on consecutive cycles. out_data=100k, out_bin 0..16, out_last only on bin 16. peak_bin=16, peak_pwr=1600, one peak_valid pulse.
- bin0=1000 in all frames; bin3 frames 1,2,3,5 -> 3*1000 beats... specifically bin0 out_data=1000 and bin3 out_data=2 (11>>>2). Other bins 0 -> peak_bin=3, peak_pwr=2, because DC is excluded.
- out_ready pseudo-random ~50% -> each bin emitted exactly once, in order. Outputs are stable during stalls and no beat is duplicated.
- out_ready=0 held, 8 frames fed -> ovf=1 after the 8th frame while the stream still presents the first average. Pulse ovf_clr -> ovf=0. Releasing out_ready completes the first spectrum only.
- Bins 4 and 9 both 500 and all others less -> peak_bin=4. Drop en after 2 frames, then raise it and feed 4 frames -> exactly one spectrum, built from the last 4 frames only.
- arst pulse while out_bin=7 -> out_valid=0, ovf=0 and peak outputs 0 immediately. After release, no output until 4 new frames arrive.
